result_arbiter: RTL and testbench

Completion-side counterpart of the dispatcher: collects finished results from `NumEus` execution units and arbitrates them round-robin onto the single register-file write port. It emits the one-cycle `wb_valid_o`/`wb_tag_o` completion pulse that frees the tag, register-table entry and wait-buffer dependencies in the dispatcher. It also tracks which tags are outstanding between dispatch and completion and flags protocol violations. It sits between the execution units and the register file / dispatcher.

---
 rtl/result_arbiter_pkg.sv | 27 ++
 rtl/result_arbiter_rr_grant.sv | 28 ++
 rtl/result_arbiter.sv | 132 +++++++++++++
 tb/tb_result_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_arbiter_pkg.sv
// Shared types for the completion path: tag/register/mask typedefs and the result payload.
package result_arbiter_pkg;

  localparam int unsigned NumTags     = 8;
  localparam int unsigned TagWidth    = $clog2(NumTags);
  localparam int unsigned RegIdxWidth = 6;
  localparam int unsigned WarpWidth   = 32;
  localparam int unsigned DataWidth   = 32;

  typedef logic [TagWidth-1:0]                    tag_t;
  typedef logic [RegIdxWidth-1:0]                 reg_idx_t;
  typedef logic [WarpWidth-1:0]                   act_mask_t;
  typedef logic [WarpWidth-1:0][DataWidth-1:0]    warp_data_t;

  typedef struct packed {
    tag_t       tag;
    reg_idx_t   dst;
    act_mask_t  act_mask;
    warp_data_t data;
  } result_t;

  // Index width for an N-entry pointer; a single entry still needs one bit.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_arbiter_rr_grant.sv
// Round-robin one-hot grant: first requester after ptr_i wins, wrapping around.
module rr_grant #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned PtrWidth = 1
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [PtrWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_c_o
);

  logic [PtrWidth-1:0] idx;
  logic                found;

  // Scan from ptr+1 for NumReq positions; the last-granted slot is visited last.
  always_comb begin
    gnt_c_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = PtrWidth'((32'(ptr_i) + off) % NumReq);
      if (!found && req_i[idx]) begin
        gnt_c_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Arbitrates EU results onto the RF write port, pulses tag completion and
// tracks outstanding tags for protocol checking.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int unsigned NumEus = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NumEus-1:0]                           eu_valid_i,
  output logic [NumEus-1:0]                           eu_ready_o,
  input  logic [NumEus-1:0][TagWidth-1:0]             eu_tag_i,
  input  logic [NumEus-1:0][RegIdxWidth-1:0]          eu_dst_i,
  input  logic [NumEus-1:0][WarpWidth-1:0]            eu_act_mask_i,
  input  logic [NumEus-1:0][WarpWidth-1:0][DataWidth-1:0] eu_data_i,
  output logic                                        rf_valid_o,
  input  logic                                        rf_ready_i,
  output logic [RegIdxWidth-1:0]                      rf_dst_o,
  output logic [WarpWidth-1:0]                        rf_act_mask_o,
  output logic [WarpWidth-1:0][DataWidth-1:0]         rf_data_o,
  output logic                                        wb_valid_o,
  output logic [TagWidth-1:0]                         wb_tag_o,
  input  logic                                        disp_handshake_i,
  input  logic [TagWidth-1:0]                         disp_tag_i,
  output logic                                        err_o
);

  localparam int unsigned PtrWidth = ptr_width(NumEus);

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  result_t             out_q, out_d;
  logic [NumTags-1:0]  outst_q, outst_d;
  logic                err_q, err_d;

  logic [NumEus-1:0]   grant_c;
  logic                load_en_c;
  logic                eu_hs_c;
  logic [PtrWidth-1:0] sel_c;
  result_t             sel_res_c;
  logic                dup_tag_c;

  rr_grant #(
    .NumReq   (NumEus),
    .PtrWidth (PtrWidth)
  ) u_rr_grant (
    .req_i   (eu_valid_i),
    .ptr_i   (ptr_q),
    .gnt_c_o (grant_c)
  );

  // Output slot frees when empty or draining this cycle; nothing is accepted in reset.
  assign load_en_c  = (!out_valid_q || rf_ready_i) && !rst_i;
  assign eu_ready_o = grant_c & {NumEus{load_en_c}};
  assign eu_hs_c    = |eu_ready_o;

  // A held result is dropped silently on reset, so both pulses are reset-qualified.
  assign rf_valid_o    = out_valid_q && !rst_i;
  assign wb_valid_o    = out_valid_q && rf_ready_i && !rst_i;
  assign wb_tag_o      = out_q.tag;
  assign rf_dst_o      = out_q.dst;
  assign rf_act_mask_o = out_q.act_mask;
  assign rf_data_o     = out_q.data;
  assign err_o         = err_q;

  // Mux the granted EU's payload.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NumEus; i++) begin
      if (grant_c[i]) sel_c = PtrWidth'(i);
    end
    sel_res_c.tag      = eu_tag_i[sel_c];
    sel_res_c.dst      = eu_dst_i[sel_c];
    sel_res_c.act_mask = eu_act_mask_i[sel_c];
    sel_res_c.data     = eu_data_i[sel_c];
  end

  // Detect two valid EUs carrying the same tag.
  always_comb begin
    dup_tag_c = 1'b0;
    for (int unsigned i = 0; i < NumEus; i++) begin
      for (int unsigned j = i + 1; j < NumEus; j++) begin
        if (eu_valid_i[i] && eu_valid_i[j] && (eu_tag_i[i] == eu_tag_i[j])) dup_tag_c = 1'b1;
      end
    end
  end

  // Next state: output slot, priority pointer, outstanding mask (clear before set) and sticky error.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    outst_d     = outst_q;
    err_d       = err_q;

    if (eu_hs_c) begin
      out_valid_d = 1'b1;
      out_d       = sel_res_c;
      ptr_d       = sel_c;
    end else if (rf_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (wb_valid_o) outst_d[out_q.tag] = 1'b0;

    if (disp_handshake_i) begin
      if (outst_d[disp_tag_i]) err_d = 1'b1;
      outst_d[disp_tag_i] = 1'b1;
    end

    if (eu_hs_c && !outst_q[sel_res_c.tag]) err_d = 1'b1;
    if (dup_tag_c) err_d = 1'b1;
  end

  // State registers with synchronous reset; EU0 gets first priority out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= PtrWidth'(NumEus - 1);
      out_valid_q <= 1'b0;
      out_q       <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Directed bench for result_arbiter with a completion scoreboard.
module tb_result_arbiter;
  import result_arbiter_pkg::*;

  localparam int unsigned NumEus = 2;

  logic                                            clk = 1'b0;
  logic                                            rst_i;
  logic [NumEus-1:0]                               eu_valid_i;
  logic [NumEus-1:0]                               eu_ready_o;
  logic [NumEus-1:0][TagWidth-1:0]                 eu_tag_i;
  logic [NumEus-1:0][RegIdxWidth-1:0]              eu_dst_i;
  logic [NumEus-1:0][WarpWidth-1:0]                eu_act_mask_i;
  logic [NumEus-1:0][WarpWidth-1:0][DataWidth-1:0] eu_data_i;
  logic                                            rf_valid_o;
  logic                                            rf_ready_i;
  logic [RegIdxWidth-1:0]                          rf_dst_o;
  logic [WarpWidth-1:0]                            rf_act_mask_o;
  logic [WarpWidth-1:0][DataWidth-1:0]             rf_data_o;
  logic                                            wb_valid_o;
  logic [TagWidth-1:0]                             wb_tag_o;
  logic                                            disp_handshake_i;
  logic [TagWidth-1:0]                             disp_tag_i;
  logic                                            err_o;

  int      n_vec  = 0;
  int      n_miss = 0;
  result_t exp_q[$];

  always #5 clk = ~clk;

  result_arbiter #(.NumEus(NumEus)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .eu_valid_i       (eu_valid_i),
    .eu_ready_o       (eu_ready_o),
    .eu_tag_i         (eu_tag_i),
    .eu_dst_i         (eu_dst_i),
    .eu_act_mask_i    (eu_act_mask_i),
    .eu_data_i        (eu_data_i),
    .rf_valid_o       (rf_valid_o),
    .rf_ready_i       (rf_ready_i),
    .rf_dst_o         (rf_dst_o),
    .rf_act_mask_o    (rf_act_mask_o),
    .rf_data_o        (rf_data_o),
    .wb_valid_o       (wb_valid_o),
    .wb_tag_o         (wb_tag_o),
    .disp_handshake_i (disp_handshake_i),
    .disp_tag_i       (disp_tag_i),
    .err_o            (err_o)
  );

  // Payload derived from (eu, tag) so every field identifies its source.
  function automatic result_t mk(int eu, int tag);
    result_t r;
    r.tag      = TagWidth'(tag);
    r.dst      = RegIdxWidth'(tag * 4 + eu);
    r.act_mask = 32'hF0F0_0000 | WarpWidth'(tag << 4) | WarpWidth'(eu);
    for (int l = 0; l < WarpWidth; l++) r.data[l] = {8'(eu + 1), 8'(tag), 16'(l)};
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_eu(int eu, bit v, int tag);
    result_t r;
    r = mk(eu, tag);
    eu_valid_i[eu]    = v;
    eu_tag_i[eu]      = r.tag;
    eu_dst_i[eu]      = r.dst;
    eu_act_mask_i[eu] = r.act_mask;
    eu_data_i[eu]     = r.data;
  endtask

  task automatic accept(int eu, int tag);
    exp_q.push_back(mk(eu, tag));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic dispatch(int tag);
    disp_handshake_i = 1'b1;
    disp_tag_i       = TagWidth'(tag);
    tick();
    disp_handshake_i = 1'b0;
  endtask

  // Monitor: every completion pulse must match the oldest expected result.
  always @(negedge clk) begin
    result_t e;
    if (wb_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL wb_unexpected: got completion of tag %0d, expected none", wb_tag_o);
      end else begin
        e = exp_q.pop_front();
        chk("wb_tag", 64'(wb_tag_o), 64'(e.tag));
        chk("wb_rf_valid", 64'(rf_valid_o), 64'd1);
        chk("rf_dst", 64'(rf_dst_o), 64'(e.dst));
        chk("rf_act_mask", 64'(rf_act_mask_o), 64'(e.act_mask));
        n_vec++;
        if (rf_data_o !== e.data) begin
          n_miss++;
          $display("FAIL rf_data: got lane0 %0h expected lane0 %0h (tag %0d)",
                   rf_data_o[0], e.data[0], e.tag);
        end
      end
    end
  end

  int t0 [4] = '{0, 2, 2, 3};
  int t1 [4] = '{1, 1, 7, 7};
  int geu[4] = '{0, 1, 0, 1};
  int gtag[4] = '{0, 1, 2, 7};

  initial begin
    result_t held;
    rst_i = 1'b1; rf_ready_i = 1'b1; disp_handshake_i = 1'b0; disp_tag_i = '0;
    eu_valid_i = '0; eu_tag_i = '0; eu_dst_i = '0; eu_act_mask_i = '0; eu_data_i = '0;

    // Reset with both EUs requesting.
    set_eu(0, 1, 3); set_eu(1, 1, 4);
    tick(); tick();
    at_neg();
    chk("rst_rf_valid", 64'(rf_valid_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_eu_ready", 64'(eu_ready_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    tick();
    rst_i = 1'b0;
    set_eu(0, 0, 0); set_eu(1, 0, 0);
    dispatch(3); dispatch(4);

    // EU0 wins first after reset, then EU1.
    set_eu(0, 1, 3); set_eu(1, 1, 4); accept(0, 3);
    at_neg(); chk("first_grant", 64'(eu_ready_o), 64'b01);
    tick();
    set_eu(0, 0, 0); accept(1, 4);
    at_neg(); chk("second_grant", 64'(eu_ready_o), 64'b10);
    tick();
    set_eu(1, 0, 0);
    at_neg(); chk("post_first_err", 64'(err_o), 64'd0);
    tick();

    // Fairness: both EUs valid, grants alternate, one completion per cycle.
    dispatch(0); dispatch(1); dispatch(2); dispatch(7); dispatch(3); dispatch(4);
    for (int k = 0; k < 4; k++) begin
      set_eu(0, 1, t0[k]); set_eu(1, 1, t1[k]); accept(geu[k], gtag[k]);
      at_neg();
      chk($sformatf("fair_grant%0d", k), 64'(eu_ready_o), 64'(1 << geu[k]));
      if (k > 0) chk($sformatf("fair_wb%0d", k), 64'(wb_valid_o), 64'd1);
      tick();
    end
    set_eu(0, 0, 0); set_eu(1, 0, 0);
    at_neg(); chk("fair_wb_last", 64'(wb_valid_o), 64'd1);
    tick();

    // Backpressure: held payload while EU1 waits.
    set_eu(0, 1, 3); accept(0, 3);
    at_neg(); chk("bp_fill_grant", 64'(eu_ready_o), 64'b01);
    tick();
    held = mk(0, 3);
    set_eu(0, 0, 0); set_eu(1, 1, 4); rf_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("bp_eu_ready", 64'(eu_ready_o), 64'd0);
      chk("bp_rf_valid", 64'(rf_valid_o), 64'd1);
      chk("bp_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("bp_dst", 64'(rf_dst_o), 64'(held.dst));
      chk("bp_data0", 64'(rf_data_o[0]), 64'(held.data[0]));
      tick();
    end
    rf_ready_i = 1'b1; accept(1, 4);
    at_neg();
    chk("bp_release_wb", 64'(wb_valid_o), 64'd1);
    chk("bp_release_grant", 64'(eu_ready_o), 64'b10);
    tick();
    set_eu(1, 0, 0);
    at_neg();
    tick();

    // Same-cycle completion and redispatch of tag 5.
    dispatch(5);
    set_eu(0, 1, 5); accept(0, 5);
    tick();
    set_eu(0, 0, 0);
    disp_handshake_i = 1'b1; disp_tag_i = TagWidth'(5);
    at_neg(); chk("reuse_wb", 64'(wb_valid_o), 64'd1);
    tick();
    disp_handshake_i = 1'b0;
    set_eu(1, 1, 5); accept(1, 5);
    at_neg(); chk("reuse_grant", 64'(eu_ready_o), 64'b10);
    tick();
    set_eu(1, 0, 0);
    at_neg(); chk("reuse_err", 64'(err_o), 64'd0);
    tick();

    // Duplicate dispatch of tag 2.
    dispatch(2);
    at_neg(); chk("dup_first_err", 64'(err_o), 64'd0);
    dispatch(2);
    at_neg(); chk("dup_err", 64'(err_o), 64'd1);
    tick();

    // Reset while a result is held: no completion pulse, error cleared.
    rf_ready_i = 1'b0;
    set_eu(0, 1, 2);
    at_neg(); chk("midrst_grant", 64'(eu_ready_o), 64'b01);
    tick();
    set_eu(0, 0, 0); rst_i = 1'b1; rf_ready_i = 1'b1;
    at_neg(); chk("midrst_wb", 64'(wb_valid_o), 64'd0);
    tick();
    rst_i = 1'b0;
    at_neg();
    chk("midrst_rf_valid", 64'(rf_valid_o), 64'd0);
    chk("midrst_err", 64'(err_o), 64'd0);
    tick();

    // Spurious completion of never-dispatched tag 6: sticky error.
    set_eu(0, 1, 6); accept(0, 6);
    at_neg();
    chk("spur_grant", 64'(eu_ready_o), 64'b01);
    chk("spur_err_before", 64'(err_o), 64'd0);
    tick();
    set_eu(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      at_neg(); chk($sformatf("spur_err%0d", k), 64'(err_o), 64'd1);
      tick();
    end

    at_neg();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
